// File: rtl/hi_lo_muldiv.sv
// rtl/hi_lo_muldiv.sv - iterative multiply/divide unit owning the HI/LO registers
module hi_lo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             unsign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               div0_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    // Multiply keeps the product in acc_q; divide keeps remainder in the upper
    // half and shifts the dividend out of / quotient into the lower half.
    always_comb begin
        sa        = ~unsign & a[WIDTH-1];
        sb        = ~unsign & b[WIDTH-1];
        abs_a     = sa ? (~a + 1'b1) : a;
        abs_b     = sb ? (~b + 1'b1) : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;

        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (op_q) begin
            if (div_ge) begin
                acc_d = {div_sub, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end

        mul_res = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo_res = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_res = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mthi_en) begin
                        hi_q <= wdata;
                    end
                    if (mtlo_en) begin
                        lo_q <= wdata;
                    end
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= sa;
                        sign_b_q <= sb;
                        div0_q   <= (b == '0);
                        a_raw_q  <= a;
                        cnt_q    <= '0;
                        if (op) begin
                            opnd_q <= abs_b;
                            acc_q  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            opnd_q <= abs_a;
                            acc_q  <= {{WIDTH{1'b0}}, abs_b};
                        end
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (!op_q) begin
                        hi_q <= mul_res[2*WIDTH-1:WIDTH];
                        lo_q <= mul_res[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// tb/tb_hi_lo_muldiv.sv - directed self-checking bench for hi_lo_muldiv
module tb_hi_lo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic        unsign;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi_en;
    logic        mtlo_en;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hi_lo_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .unsign  (unsign),
        .a       (a),
        .b       (b),
        .mthi_en (mthi_en),
        .mtlo_en (mtlo_en),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    // Start pulse spans one posedge (E0); returns at the negedge after E0
    // with operands scrambled to show they are captured.
    task automatic launch(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op     = o;
        unsign = u;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
    endtask

    // Sample ncyc negedges, the current one being index 1.
    task automatic observe(input int ncyc, output int nbusy, output int ndone, output int done_at);
        nbusy   = 0;
        ndone   = 0;
        done_at = 0;
        for (int i = 1; i <= ncyc; i++) begin
            if (i > 1) @(negedge clk);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = i;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        mthi_en = 1'b1;
        mtlo_en = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi_en = 1'b0;
        mtlo_en = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_mul_unsigned();
        int nb, nd, at;
        launch(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe(36, nb, nd, at);
        checks++; if (nb != 33) begin errors++; $display("FAIL mulu_busy_cycles: got %0d expected 33", nb); end
        checks++; if (at != 34) begin errors++; $display("FAIL mulu_done_cycle: got %0d expected 34", at); end
        checks++; if (nd != 1) begin errors++; $display("FAIL mulu_done_count: got %0d expected 1", nd); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulu_hi: got %h expected %h", hi, 32'hFFFF_FFFE); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL mulu_lo: got %h expected %h", lo, 32'h0000_0001); end
    endtask

    task automatic test_mul_signed();
        int nb, nd, at;
        launch(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5);
        observe(36, nb, nd, at);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL muls_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL muls_lo: got %h expected %h", lo, 32'hFFFF_FFF1); end
        checks++; if (at != 34) begin errors++; $display("FAIL muls_done_cycle: got %0d expected 34", at); end
    endtask

    task automatic test_div_signed();
        int nb, nd, at;
        launch(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        observe(36, nb, nd, at);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divs_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divs_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (nb != 33) begin errors++; $display("FAIL divs_busy_cycles: got %0d expected 33", nb); end
    endtask

    task automatic test_div_unsigned();
        int nb, nd, at;
        launch(1'b1, 1'b1, 32'd7, 32'd2);
        observe(36, nb, nd, at);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo, 32'd3); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected %h", hi, 32'd1); end
        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        observe(36, nb, nd, at);
        checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big_lo: got %h expected %h", lo, 32'h7FFF_FFFC); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_big_hi: got %h expected %h", hi, 32'd1); end
    endtask

    task automatic test_div_overflow();
        int nb, nd, at;
        launch(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        observe(36, nb, nd, at);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected %h", hi, 32'h0); end
    endtask

    task automatic test_div_zero();
        int nb, nd, at;
        launch(1'b1, 1'b1, 32'h0000_1234, 32'h0);
        observe(36, nb, nd, at);
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL div0_hi: got %h expected %h", hi, 32'h0000_1234); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
        checks++; if (nd != 1) begin errors++; $display("FAIL div0_done_count: got %0d expected 1", nd); end
        checks++; if (nb != 33) begin errors++; $display("FAIL div0_busy_cycles: got %0d expected 33", nb); end
        launch(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0);
        observe(36, nb, nd, at);
        checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0s_hi: got %h expected %h", hi, 32'hFFFF_FFF9); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0s_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
    endtask

    task automatic test_mt_idle();
        @(negedge clk);
        mtlo_en = 1'b1;
        wdata   = 32'h55;
        @(negedge clk);
        mtlo_en = 1'b0;
        checks++; if (lo !== 32'h55) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", lo, 32'h55); end
        checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected %h", hi, 32'hFFFF_FFF9); end
        mthi_en = 1'b1;
        mtlo_en = 1'b1;
        wdata   = 32'h77;
        @(negedge clk);
        mthi_en = 1'b0;
        mtlo_en = 1'b0;
        checks++; if (hi !== 32'h77) begin errors++; $display("FAIL mtboth_hi: got %h expected %h", hi, 32'h77); end
        checks++; if (lo !== 32'h77) begin errors++; $display("FAIL mtboth_lo: got %h expected %h", lo, 32'h77); end
    endtask

    task automatic test_mthi_busy();
        int nb, nd, at;
        launch(1'b0, 1'b1, 32'h0001_0000, 32'h0003_0000);
        repeat (3) @(negedge clk);
        mthi_en = 1'b1;
        wdata   = 32'hAA;
        @(negedge clk);
        mthi_en = 1'b0;
        checks++; if (hi !== 32'h77) begin errors++; $display("FAIL mthi_busy_mid: got %h expected %h", hi, 32'h77); end
        observe(36, nb, nd, at);
        checks++; if (hi !== 32'h3) begin errors++; $display("FAIL mthi_busy_hi: got %h expected %h", hi, 32'h3); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_busy_lo: got %h expected %h", lo, 32'h0); end
    endtask

    task automatic test_mt_with_start();
        int nb, nd, at;
        @(negedge clk);
        op      = 1'b0;
        unsign  = 1'b1;
        a       = 32'd2;
        b       = 32'd3;
        start   = 1'b1;
        mthi_en = 1'b1;
        wdata   = 32'hCC;
        @(negedge clk);
        start   = 1'b0;
        mthi_en = 1'b0;
        checks++; if (hi !== 32'hCC) begin errors++; $display("FAIL mtstart_hi_written: got %h expected %h", hi, 32'hCC); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mtstart_busy: got %b expected 1", busy); end
        observe(36, nb, nd, at);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mtstart_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h6) begin errors++; $display("FAIL mtstart_lo: got %h expected %h", lo, 32'h6); end
    endtask

    task automatic test_start_while_busy();
        int nb, nd, at;
        launch(1'b0, 1'b1, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        observe(40, nb, nd, at);
        checks++; if (nd != 1) begin errors++; $display("FAIL sbusy_done_count: got %0d expected 1", nd); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL sbusy_lo: got %h expected %h", lo, 32'd12); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL sbusy_hi: got %h expected %h", hi, 32'd0); end
    endtask

    task automatic test_reset_mid();
        int nb, nd, at;
        launch(1'b1, 1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", lo, 32'h0); end
        observe(40, nb, nd, at);
        checks++; if (nd != 0) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 0", nd); end
        checks++; if (nb != 0) begin errors++; $display("FAIL rstmid_busy_after: got %0d expected 0", nb); end
    endtask

    task automatic test_back_to_back();
        int  nb, nd, at;
        bit  seen;
        launch(1'b0, 1'b1, 32'd6, 32'd7);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_done: got timeout expected done"); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", lo, 32'd42); end
        op     = 1'b1;
        unsign = 1'b1;
        a      = 32'd100;
        b      = 32'd7;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        observe(36, nb, nd, at);
        checks++; if (nb != 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 33", nb); end
        checks++; if (at != 34) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 34", at); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'd2); end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        unsign  = 1'b0;
        a       = '0;
        b       = '0;
        mthi_en = 1'b0;
        mtlo_en = 1'b0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;

        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div_signed();
        test_div_unsigned();
        test_div_overflow();
        test_div_zero();
        test_mt_idle();
        test_mthi_busy();
        test_mt_with_start();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hi_lo_muldiv.md
Name: hi_lo_muldiv

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers. It is the consumer end of the ALU's 64-bit MULT/DIV result path. It accepts an operation from the execute stage, computes over 33 cycles using shift-add or restoring division, then commits to HI/LO. It also serves MTHI/MTLO writes and MFHI/MFLO reads, and drives busy so the control unit can stall.

Parameters:
WIDTH, 32, operand and HI/LO register width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  1  0 = multiply, 1 = divide
unsign  input  1  1 = unsigned (MULTU/DIVU), 0 = signed
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
mthi_en  input  1  write wdata to HI
mtlo_en  input  1  write wdata to LO
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register (product upper word / remainder)
lo  output  WIDTH  LO register (product lower word / quotient)
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle

Behaviour:
- Reset state: IDLE; hi=0, lo=0, busy=0, done=0; iteration counter=0. Reset mid-operation aborts with no HI/LO commit and no done pulse.
- States and transitions:
  - IDLE -> RUN on start. Capture operands: |a|, |b| if signed, raw values if unsigned. Record sign_a and sign_b; record op.
  - RUN: one iteration per edge for WIDTH edges, counter 0..WIDTH-1. Transition to FINISH after the edge where counter = WIDTH-1.
  - FINISH: one edge. Apply sign fixup, write hi/lo, set done=1 for the next cycle, go to IDLE.
- Timing: start sampled at edge E0. busy=1 from after E0 through after E32 (33 cycles). HI/LO update at E33. done=1 in the cycle after E33, then 0.
- Multiply (shift-add):
  - 2*WIDTH accumulator.
  - Signed result is negated if sign_a xor sign_b.
  - hi = result[63:32], lo = result[31:0].
- Divide (restoring):
  - Partial remainder is WIDTH+1 bits wide.
  - Signed quotient is negated if sign_a xor sign_b; signed remainder takes the sign of a.
  - lo = quotient, hi = remainder.
- Divide by zero (b=0, either signedness): hi = a (unmodified), lo = all ones. Still takes 33 cycles.
- Signed -2^31 / -1: lo = 0x80000000, hi = 0.
- start while busy: ignored; no queueing.
- mthi_en/mtlo_en in IDLE: write at that edge.
- mthi_en/mtlo_en while busy: ignored.
- mthi_en/mtlo_en together with start in IDLE: the write happens, start is accepted, and the operation result overwrites at E33.
- mthi_en and mtlo_en together: both registers are written.
- hi/lo are stable between commits. Reads are combinational from the registers, with no extra latency.
- Operand inputs may change after E0 without affecting the result.

Test Plan:
- Unsigned mult: a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; done in the 34th cycle after E0; hi=0xFFFFFFFE, lo=0x00000001.
- Signed mult: a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Division:
  - signed a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - unsigned a=7, b=2 -> lo=3, hi=1
  - signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0
- Divide by zero: a=0x00001234, b=0 -> hi=0x00001234, lo=0xFFFFFFFF, one done pulse.
- Handshake:
  - start again at cycle 5 of an operation -> ignored; exactly one done.
  - mthi_en=1, wdata=0xAA during busy -> hi shows the operation result, not 0xAA.
  - mtlo_en=1, wdata=0x55 in IDLE -> lo=0x55 next cycle.
- Reset at cycle 10 of a divide -> next cycle busy=0, hi=lo=0; done never asserted.
- A new start immediately after the done cycle is accepted.
